// File: rtl/pinmux_pkg.sv
// ---------------------------------------------------------------------------
// pinmux_pkg
// Shared types and constants for the pinmux pad reconfiguration sequencer.
//   state_e       : sequencer states (IDLE, QUIESCE, SWITCH, SETTLE, ENABLE)
//   pinmux_cfg_t  : one pad configuration at the default field widths
//   PINMUX_*      : default widths used by the sequencer and its settle timer
// ---------------------------------------------------------------------------
package pinmux_pkg;

   localparam int PINMUX_SEL_WIDTH    = 5;
   localparam int PINMUX_INFUNC_WIDTH = 32;
   // Settle windows are limited to 0..255 cycles, so an 8-bit counter suffices.
   localparam int PINMUX_CNT_WIDTH    = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      QUIESCE = 3'd1,
      SWITCH  = 3'd2,
      SETTLE  = 3'd3,
      ENABLE  = 3'd4
   } state_e;

   // Default-width view of a configuration. The sequencer declares the same
   // layout locally so that its width parameters can be overridden.
   typedef struct packed {
      logic [PINMUX_SEL_WIDTH-1:0]    outfunc_sel;
      logic [PINMUX_INFUNC_WIDTH-1:0] infunc_en;
      logic                           od;
      logic                           ie;
      logic                           pad_en;
   } pinmux_cfg_t;

endpackage : pinmux_pkg

// File: rtl/pinmux_settle_timer.sv
// ---------------------------------------------------------------------------
// pinmux_settle_timer
// Load-and-decrement counter shared by the QUIESCE and SETTLE windows.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this edge (takes priority over decrement)
//   load_val   : window length in cycles
//   done       : count has reached zero
// ---------------------------------------------------------------------------
module pinmux_settle_timer
   import pinmux_pkg::*;
#(
   parameter int CNT_WIDTH = PINMUX_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   output logic                 done
);

   logic [CNT_WIDTH-1:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done = (count_q == '0);

endmodule : pinmux_settle_timer

// File: rtl/pinmux_reconfig_seq.sv
// ---------------------------------------------------------------------------
// pinmux_reconfig_seq
// Run-time reconfiguration sequencer for one pinmux pad cell. A request
// tri-states the pad and blocks input distribution, waits a settle window,
// switches function select / OD / IE, waits a second window, then re-enables
// the pad and the input functions and acknowledges.
//
// Optional build macro: PINMUX_PES_EN adds a sticky port-stop that forces
// o_gpioquten low on any enabled error event until cleared.
//
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_cfg_req           : single-cycle request, honoured only in IDLE
//   i_cfg_outfunc_sel   : requested output function select
//   i_cfg_infunc_en     : requested input function enables
//   i_cfg_od, i_cfg_ie  : requested open-drain / input-enable controls
//   i_cfg_pad_en        : re-enable pad output after switching
//   o_cfg_ack           : one-cycle pulse, new config fully applied
//   o_cfg_drop          : one-cycle pulse, request seen while busy and ignored
//   o_busy              : sequencer not in IDLE
//   o_outfunc_sel, o_infunc_en, o_pinctlx_od, o_pinctlx_ie, o_gpioquten
//                       : registered pad cell controls
//   i_pes_err, i_pes_en, i_pes_clr, o_pes_active (PINMUX_PES_EN only)
//                       : error events, per-event enables, clear, port-stop
// ---------------------------------------------------------------------------
module pinmux_reconfig_seq
   import pinmux_pkg::*;
#(
   parameter int SEL_WIDTH     = PINMUX_SEL_WIDTH,
   parameter int INFUNC_WIDTH  = PINMUX_INFUNC_WIDTH,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_cfg_req,
   input  logic [SEL_WIDTH-1:0]    i_cfg_outfunc_sel,
   input  logic [INFUNC_WIDTH-1:0] i_cfg_infunc_en,
   input  logic                    i_cfg_od,
   input  logic                    i_cfg_ie,
   input  logic                    i_cfg_pad_en,
   output logic                    o_cfg_ack,
   output logic                    o_cfg_drop,
   output logic                    o_busy,
   output logic [SEL_WIDTH-1:0]    o_outfunc_sel,
   output logic [INFUNC_WIDTH-1:0] o_infunc_en,
   output logic                    o_pinctlx_od,
   output logic                    o_pinctlx_ie,
`ifdef PINMUX_PES_EN
   input  logic [7:0]              i_pes_err,
   input  logic [7:0]              i_pes_en,
   input  logic                    i_pes_clr,
   output logic                    o_pes_active,
`endif
   output logic                    o_gpioquten
);

   // Same layout as pinmux_cfg_t, sized by this instance's parameters.
   typedef struct packed {
      logic [SEL_WIDTH-1:0]    outfunc_sel;
      logic [INFUNC_WIDTH-1:0] infunc_en;
      logic                    od;
      logic                    ie;
      logic                    pad_en;
   } cfg_t;

   state_e state_q, state_d;
   cfg_t   shadow_q, shadow_d;

   logic   timer_load;
   logic   timer_done;

   // Next-cycle values of the registered outputs.
   logic [SEL_WIDTH-1:0]    sel_d;
   logic [INFUNC_WIDTH-1:0] infunc_d;
   logic                    od_d, ie_d;
   logic                    ack_d, drop_d, busy_d;
   // Pad enable as applied by the sequencer, before any port-stop masking.
   // Kept separately so the pad returns to it once a port-stop is cleared.
   logic                    pad_en_q, pad_en_d;
   logic                    gpioquten_d;

   logic                    capture;
   assign capture = (state_q == IDLE) && i_cfg_req;

   // ---------------- settle timer ----------------
   // Reloaded on entry into either wait state; the state stays put until the
   // count has run down to zero, giving SETTLE_CYCLES+1 cycles per window.
   assign timer_load = ((state_d == QUIESCE) && (state_q != QUIESCE)) ||
                       ((state_d == SETTLE)  && (state_q != SETTLE));

   pinmux_settle_timer #(
      .CNT_WIDTH (PINMUX_CNT_WIDTH)
   ) u_timer (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .load     (timer_load),
      .load_val (PINMUX_CNT_WIDTH'(SETTLE_CYCLES)),
      .done     (timer_done)
   );

   // ---------------- state register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   // NOTE: every always_comb output is given a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (i_cfg_req)  state_d = QUIESCE;
         QUIESCE: if (timer_done) state_d = SWITCH;
         SWITCH:                  state_d = SETTLE;
         SETTLE:  if (timer_done) state_d = ENABLE;
         ENABLE:                  state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Decoded from the next state so the registered outputs change on the same
   // edge the state does (e.g. pad tri-stated in the first QUIESCE cycle).
   always_comb begin
      shadow_d = shadow_q;
      if (capture) begin
         shadow_d.outfunc_sel = i_cfg_outfunc_sel;
         shadow_d.infunc_en   = i_cfg_infunc_en;
         shadow_d.od          = i_cfg_od;
         shadow_d.ie          = i_cfg_ie;
         shadow_d.pad_en      = i_cfg_pad_en;
      end

      sel_d    = o_outfunc_sel;
      infunc_d = o_infunc_en;
      od_d     = o_pinctlx_od;
      ie_d     = o_pinctlx_ie;
      pad_en_d = pad_en_q;
      ack_d    = 1'b0;
      busy_d   = (state_d != IDLE);
      drop_d   = i_cfg_req && (state_q != IDLE);

      unique case (state_d)
         QUIESCE, SETTLE: begin
            infunc_d = '0;
            pad_en_d = 1'b0;
         end
         SWITCH: begin
            sel_d    = shadow_q.outfunc_sel;
            od_d     = shadow_q.od;
            ie_d     = shadow_q.ie;
            infunc_d = '0;
            pad_en_d = 1'b0;
         end
         ENABLE: begin
            infunc_d = shadow_q.infunc_en;
            pad_en_d = shadow_q.pad_en;
            ack_d    = 1'b1;
         end
         default: ;  // IDLE holds the last applied config
      endcase
   end

`ifdef PINMUX_PES_EN
   // ---------------- port-stop ----------------
   // A new enabled error wins over a simultaneous clear.
   logic pes_hit;
   logic pes_active_d;

   assign pes_hit      = |(i_pes_err & i_pes_en);
   assign pes_active_d = pes_hit | (o_pes_active & ~i_pes_clr);
   assign gpioquten_d  = pad_en_d & ~pes_active_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pes_active <= 1'b0;
      end else begin
         o_pes_active <= pes_active_d;
      end
   end
`else
   assign gpioquten_d = pad_en_d;
`endif

   // ---------------- output and shadow registers ----------------
   // NOTE: the shadow register is reset as well, so an aborted request leaves
   // nothing behind that a later sequence could pick up.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shadow_q      <= '0;
         pad_en_q      <= 1'b0;
         o_outfunc_sel <= '0;
         o_infunc_en   <= '0;
         o_pinctlx_od  <= 1'b0;
         o_pinctlx_ie  <= 1'b0;
         o_gpioquten   <= 1'b0;
         o_cfg_ack     <= 1'b0;
         o_cfg_drop    <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         pad_en_q      <= pad_en_d;
         o_outfunc_sel <= sel_d;
         o_infunc_en   <= infunc_d;
         o_pinctlx_od  <= od_d;
         o_pinctlx_ie  <= ie_d;
         o_gpioquten   <= gpioquten_d;
         o_cfg_ack     <= ack_d;
         o_cfg_drop    <= drop_d;
         o_busy        <= busy_d;
      end
   end

endmodule : pinmux_reconfig_seq

// File: tb/tb_pinmux_reconfig_seq.sv
// ---------------------------------------------------------------------------
// tb_pinmux_reconfig_seq
// Directed bench for pinmux_reconfig_seq. Instance dut uses SETTLE_CYCLES=4,
// instance dut0 uses SETTLE_CYCLES=0. Inputs change and outputs are sampled
// on the falling clock edge. Port-stop scenarios run when PINMUX_PES_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_pinmux_reconfig_seq;

   localparam int SW = 5;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic          req0 = 1'b0;
   logic [SW-1:0] sel_in = '0;
   logic [IW-1:0] inf_in = '0;
   logic          od_in = 1'b0;
   logic          ie_in = 1'b0;
   logic          pad_in = 1'b0;

   logic          ack, drop, busy, od, ie, gq;
   logic [SW-1:0] sel;
   logic [IW-1:0] inf;
   logic          ack0, drop0, busy0, od0, ie0, gq0;
   logic [SW-1:0] sel0;
   logic [IW-1:0] inf0;

`ifdef PINMUX_PES_EN
   logic [7:0]    pes_err = '0;
   logic [7:0]    pes_en = '0;
   logic          pes_clr = 1'b0;
   logic          pes_act, pes_act0;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pinmux_reconfig_seq #(.SEL_WIDTH(SW), .INFUNC_WIDTH(IW), .SETTLE_CYCLES(4)) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_cfg_req         (req),
      .i_cfg_outfunc_sel (sel_in),
      .i_cfg_infunc_en   (inf_in),
      .i_cfg_od          (od_in),
      .i_cfg_ie          (ie_in),
      .i_cfg_pad_en      (pad_in),
      .o_cfg_ack         (ack),
      .o_cfg_drop        (drop),
      .o_busy            (busy),
      .o_outfunc_sel     (sel),
      .o_infunc_en       (inf),
      .o_pinctlx_od      (od),
      .o_pinctlx_ie      (ie),
`ifdef PINMUX_PES_EN
      .i_pes_err         (pes_err),
      .i_pes_en          (pes_en),
      .i_pes_clr         (pes_clr),
      .o_pes_active      (pes_act),
`endif
      .o_gpioquten       (gq)
   );

   pinmux_reconfig_seq #(.SEL_WIDTH(SW), .INFUNC_WIDTH(IW), .SETTLE_CYCLES(0)) dut0 (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_cfg_req         (req0),
      .i_cfg_outfunc_sel (sel_in),
      .i_cfg_infunc_en   (inf_in),
      .i_cfg_od          (od_in),
      .i_cfg_ie          (ie_in),
      .i_cfg_pad_en      (pad_in),
      .o_cfg_ack         (ack0),
      .o_cfg_drop        (drop0),
      .o_busy            (busy0),
      .o_outfunc_sel     (sel0),
      .o_infunc_en       (inf0),
      .o_pinctlx_od      (od0),
      .o_pinctlx_ie      (ie0),
`ifdef PINMUX_PES_EN
      .i_pes_err         (pes_err),
      .i_pes_en          (pes_en),
      .i_pes_clr         (pes_clr),
      .o_pes_active      (pes_act0),
`endif
      .o_gpioquten       (gq0)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one request into dut; returns at the falling edge right after the
   // capturing edge (cycle index 0 of the sequence).
   task automatic issue(input logic [SW-1:0] s, input logic [IW-1:0] f,
                        input logic o, input logic i, input logic p);
      @(negedge clk);
      sel_in = s; inf_in = f; od_in = o; ie_in = i; pad_in = p;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   // Starting at cycle index n0 (already at a falling edge), steps until dut
   // acks. Reports ack cycle index, cycles with gpioquten low before ack, and
   // the first cycle index at which the select showed sel_tgt.
   task automatic run_to_ack(input int n0, input logic [SW-1:0] sel_tgt,
                             output int ack_n, output int low_n, output int sel_n);
      ack_n = -1; low_n = 0; sel_n = -1;
      for (int n = n0; n < n0 + 40; n++) begin
         if (n != n0) @(negedge clk);
         if (sel === sel_tgt && sel_n < 0) sel_n = n;
         if (ack === 1'b1) begin
            ack_n = n;
            break;
         end
         if (gq !== 1'b1) low_n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int an, ln, sn;
      int a0, l0, s0;
      int ack_cnt, busy_cnt;

      // ---------------- reset ----------------
      #12;
      check("rst_busy", busy, 0);
      check("rst_gq",   gq,   0);
      check("rst_sel",  sel,  0);
      check("rst_inf",  inf,  0);
      check("rst_ack",  ack,  0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // ---------------- basic sequence, SETTLE=4 ----------------
      issue(5'd3, 32'h5, 1'b0, 1'b1, 1'b1);
      check("t1_busy0", busy, 1);
      check("t1_gq0",   gq,   0);
      check("t1_inf0",  inf,  0);
      run_to_ack(0, 5'd3, an, ln, sn);
      check("t1_ack_lat",   an, 11);
      check("t1_gq_low",    ln, 11);
      check("t1_sel_cycle", sn, 5);
      check("t1_ack_gq",    gq, 1);
      check("t1_ack_inf",   inf, 32'h5);
      check("t1_ack_sel",   sel, 3);
      check("t1_ack_od",    od, 0);
      check("t1_ack_ie",    ie, 1);
      @(negedge clk);
      check("t1_post_ack",  ack, 0);
      check("t1_post_busy", busy, 0);
      check("t1_post_gq",   gq, 1);

      // ---------------- drop while busy, ENABLE drop, accept after ack ----------------
      issue(5'd9, 32'hA5A5_0000, 1'b1, 1'b0, 1'b1);
      check("t2_gq0", gq, 0);
      for (int n = 1; n <= 8; n++) @(negedge clk);
      check("t2_sel_settle", sel, 9);
      sel_in = 5'd17; inf_in = 32'hFFFF_FFFF; req = 1'b1;
      @(negedge clk);                       // cycle 9
      req = 1'b0;
      check("t2_drop",      drop, 1);
      check("t2_drop_sel",  sel, 9);
      check("t2_drop_busy", busy, 1);
      @(negedge clk);                       // cycle 10
      check("t2_drop_pulse", drop, 0);
      run_to_ack(10, 5'd9, an, ln, sn);
      check("t2_ack_lat", an, 11);
      check("t2_ack_sel", sel, 9);
      check("t2_ack_inf", inf, 32'hA5A5_0000);
      check("t2_ack_od",  od, 1);
      check("t2_ack_ie",  ie, 0);
      check("t2_ack_gq",  gq, 1);
      // request in the ENABLE cycle is dropped, held into IDLE it is taken
      sel_in = 5'd17; inf_in = 32'h0000_00F0; od_in = 1'b0; ie_in = 1'b1; pad_in = 1'b0;
      req = 1'b1;
      @(negedge clk);                       // cycle 12
      check("t2_en_drop", drop, 1);
      check("t2_en_busy", busy, 0);
      @(negedge clk);                       // cycle 13: captured at previous edge
      req = 1'b0;
      check("t2_acc_busy", busy, 1);
      check("t2_acc_drop", drop, 0);
      check("t2_acc_gq",   gq, 0);
      check("t2_acc_inf",  inf, 0);
      run_to_ack(13, 5'd17, an, ln, sn);
      check("t2_acc_lat",  an, 24);
      check("t2_acc_selc", sn, 18);
      check("t2_acc_gq_a", gq, 0);
      check("t2_acc_inf_a", inf, 32'h0000_00F0);
      check("t2_acc_sel_a", sel, 17);
      check("t2_acc_ie_a",  ie, 1);

      // ---------------- SETTLE_CYCLES=0 instance ----------------
      @(negedge clk);
      sel_in = 5'd6; inf_in = 32'h3C; od_in = 1'b1; ie_in = 1'b1; pad_in = 1'b1;
      req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      a0 = -1; l0 = 0; s0 = -1;
      for (int n = 0; n < 20; n++) begin
         if (n != 0) @(negedge clk);
         if (sel0 === 5'd6 && s0 < 0) s0 = n;
         if (ack0 === 1'b1) begin
            a0 = n;
            break;
         end
         if (gq0 !== 1'b1) l0++;
      end
      check("t3_ack_lat", a0, 3);
      check("t3_gq_low",  l0, 3);
      check("t3_sel_cyc", s0, 1);
      check("t3_ack_gq",  gq0, 1);
      check("t3_ack_inf", inf0, 32'h3C);
      @(negedge clk);
      check("t3_post_ack", ack0, 0);

      // ---------------- async reset mid-sequence ----------------
      issue(5'd12, 32'hFF, 1'b1, 1'b1, 1'b1);
      for (int n = 1; n <= 7; n++) @(negedge clk);
      check("t4_sel_mid",  sel, 12);
      check("t4_busy_mid", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_rst_sel",  sel, 0);
      check("t4_rst_inf",  inf, 0);
      check("t4_rst_od",   od, 0);
      check("t4_rst_ie",   ie, 0);
      check("t4_rst_gq",   gq, 0);
      check("t4_rst_busy", busy, 0);
      check("t4_rst_ack",  ack, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      ack_cnt = 0; busy_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ack !== 1'b0) ack_cnt++;
         if (busy !== 1'b0) busy_cnt++;
      end
      check("t4_no_ack",  ack_cnt, 0);
      check("t4_no_busy", busy_cnt, 0);
      check("t4_idle_sel", sel, 0);

`ifdef PINMUX_PES_EN
      // ---------------- port-stop ----------------
      issue(5'd2, 32'h1, 1'b0, 1'b1, 1'b1);
      run_to_ack(0, 5'd2, an, ln, sn);
      check("p1_ack_lat", an, 11);
      @(negedge clk);
      check("p1_gq_on",  gq, 1);
      check("p1_act0",   pes_act, 0);
      pes_en = 8'h04; pes_err = 8'h01;      // event not enabled
      @(negedge clk);
      check("p1_masked_act", pes_act, 0);
      check("p1_masked_gq",  gq, 1);
      pes_err = 8'h04;
      @(negedge clk);
      pes_err = 8'h00;
      check("p1_act",    pes_act, 1);
      check("p1_gq_off", gq, 0);
      @(negedge clk);
      check("p1_sticky", pes_act, 1);
      pes_clr = 1'b1;
      @(negedge clk);
      pes_clr = 1'b0;
      check("p1_clr_act", pes_act, 0);
      check("p1_clr_gq",  gq, 1);
      // error held against clear: error wins
      pes_err = 8'h04; pes_clr = 1'b1;
      @(negedge clk);
      check("p2_act_a", pes_act, 1);
      @(negedge clk);
      check("p2_act_b", pes_act, 1);
      check("p2_gq",    gq, 0);
      pes_err = 8'h00; pes_clr = 1'b0;
      issue(5'd4, 32'h2, 1'b0, 1'b0, 1'b1);
      run_to_ack(0, 5'd4, an, ln, sn);
      check("p2_ack_lat", an, 11);
      check("p2_gq_low",  ln, 11);
      check("p2_ack_gq",  gq, 0);
      check("p2_ack_inf", inf, 32'h2);
      check("p2_ack_sel", sel, 4);
      @(negedge clk);
      pes_clr = 1'b1;
      @(negedge clk);
      pes_clr = 1'b0;
      check("p2_clr_gq",  gq, 1);
      check("p2_clr_act", pes_act, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pinmux_reconfig_seq
